// File: rtl/sram_like_arbiter_2x1_pkg.sv
// sram_like_arbiter_2x1_pkg: shared FSM encoding and source ids for the sram-like bridge blocks
package sram_like_arbiter_2x1_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;
endpackage

// File: rtl/sram_like_arbiter_2x1.sv
// sram_like_arbiter_2x1: round-robin merge of inst/data sram-like ports onto one master, one transaction in flight
module sram_like_arbiter_2x1
  import sram_like_arbiter_2x1_pkg::*;
#(
  parameter logic DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        grant_data
);
  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d, last_q, last_d;
  logic       idle, any_req, win, sel, active, addr_hit, data_hit;
  assign idle     = state_q == ST_IDLE;
  assign any_req  = inst_req | data_req;
  // last_q resets to the side opposite DATA_FIRST, so the first tie naturally follows it
  assign win      = (inst_req & data_req) ? ~last_q : (data_req ? SRC_DATA : SRC_INST);
  assign sel      = idle ? win : owner_q;
  // rst gating keeps outputs low while reset is held, even with requests pending
  assign active   = ~rst & ((idle & any_req) | (state_q == ST_ADDR));
  assign addr_hit = active & m_addr_ok;
  assign data_hit = ~rst & (state_q == ST_DATA) & m_data_ok;
  assign m_req        = active;
  assign m_wr         = active & (sel ? data_wr : inst_wr);
  assign m_size       = active ? (sel ? data_size : inst_size) : 2'd0;
  assign m_addr       = active ? (sel ? data_addr : inst_addr) : 32'd0;
  assign m_wdata      = active ? (sel ? data_wdata : inst_wdata) : 32'd0;
  assign inst_addr_ok = addr_hit & (sel == SRC_INST);
  assign data_addr_ok = addr_hit & (sel == SRC_DATA);
  assign inst_data_ok = data_hit & (owner_q == SRC_INST);
  assign data_data_ok = data_hit & (owner_q == SRC_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign grant_data   = owner_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (idle & any_req) begin
      owner_d = win;
      state_d = m_addr_ok ? ST_DATA : ST_ADDR;
    end else if ((state_q == ST_ADDR) & m_addr_ok) begin
      state_d = ST_DATA;
    end else if (data_hit) begin
      state_d = ST_IDLE;
      last_d  = owner_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= SRC_INST;
      last_q  <= DATA_FIRST ? SRC_INST : SRC_DATA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: doc/sram_like_arbiter_2x1.md
SRAM_LIKE_ARBITER_2X1 -- requirements
Module: sram_like_arbiter_2x1

Interface
REQ-001 SHALL have parameter DATA_FIRST, default 1, meaning tie-break for the first simultaneous request after reset (1 = data port wins).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports inst_req/inst_wr, input, 1 each: instruction-side sram-like request and write flag.
REQ-005 SHALL have ports inst_size, input, 2; inst_addr, input, 32; inst_wdata, input, 32: instruction-side request fields.
REQ-006 SHALL have ports inst_addr_ok/inst_data_ok, output, 1 each; inst_rdata, output, 32: instruction-side responses.
REQ-007 SHALL have ports data_req, data_wr, data_size, data_addr, data_wdata (inputs) and data_addr_ok, data_data_ok, data_rdata (outputs), with the same widths and meanings as the instruction side.
REQ-008 SHALL have ports m_req, m_wr, m_size, m_addr, m_wdata, outputs, widths 1/1/2/32/32: merged master request toward the AXI interface.
REQ-009 SHALL have ports m_addr_ok/m_data_ok, input, 1 each; m_rdata, input, 32: master responses.
REQ-010 SHALL have port grant_data, output, 1: current owner (1 = data, 0 = inst), for debug.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ADDR (grant locked, awaiting m_addr_ok) and DATA (address accepted, awaiting m_data_ok).
REQ-012 SHALL allow at most one outstanding master transaction.
REQ-013 SHALL select the winner in IDLE combinationally:
- only one requester asserting req: that requester wins;
- both asserting req: the requester not granted last wins (round-robin);
- no transaction since reset: the winner follows DATA_FIRST.
REQ-014 SHALL, in IDLE with a winner, drive m_req=1 and the winner's wr, size, addr and wdata onto m_* in the same cycle (zero-cycle latency).
REQ-015 SHALL, in IDLE, take one of two paths:
- m_addr_ok in the same cycle: assert the winner's addr_ok that cycle, latch the owner, go to DATA;
- otherwise: latch the owner and go to ADDR.
REQ-016 SHALL, in ADDR, keep forwarding only the latched owner's request fields, ignoring the other requester, until m_addr_ok.
- On m_addr_ok: assert the owner's addr_ok that cycle and go to DATA.
REQ-017 SHALL, in DATA, hold m_req=0; on m_data_ok, assert the owner's data_ok that cycle, record the owner as last-granted, and return to IDLE.
REQ-018 SHALL NOT issue a new m_req in the cycle m_data_ok arrives; the next grant is evaluated in IDLE on the following cycle.
REQ-019 SHALL drive inst_rdata and data_rdata as a combinational copy of m_rdata, valid only when the corresponding data_ok is high.
REQ-020 SHALL never assert addr_ok or data_ok to the non-owner.
REQ-021 SHALL ignore m_data_ok received in IDLE or ADDR (not forwarded, no state change).
REQ-022 SHALL ignore m_addr_ok received in DATA.
REQ-023 SHALL hold m_wr, m_size, m_addr and m_wdata at 0 whenever m_req=0.

Reset
REQ-024 SHALL, on rst assertion at any time including mid-transaction, immediately (asynchronously) force:
- state=IDLE, grant_data=0;
- last-granted = the side opposite DATA_FIRST's winner;
- all outputs 0 (m_req, both addr_ok/data_ok).
REQ-025 SHALL NOT replay or complete an aborted transaction after reset release.

Structure
REQ-026 SHALL place the FSM state encoding and the constants SRC_INST=0 and SRC_DATA=1 in a shared package used by the bridge blocks.
REQ-027 SHALL be a single module; no sub-module is warranted.

Verification
REQ-028 SHALL cover simultaneous requests after reset: inst_req=data_req=1 (inst_addr 0xBFC00000, data_addr 0x80001000), m_addr_ok=1 immediately, m_data_ok two cycles later -> data served first (data_addr_ok then data_data_ok with rdata 0x12345678), then inst served, m_addr=0xBFC00000.
REQ-029 SHALL cover a stalled address phase: inst granted and m_addr_ok held low 3 cycles while data_req rises -> m_addr remains the inst address all 3 cycles; data_addr_ok stays 0.
REQ-030 SHALL cover round-robin fairness: both sides request continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-031 SHALL cover a spurious response: m_data_ok pulsed in IDLE -> no data_ok on either side; state stays IDLE.
REQ-032 SHALL cover reset mid-operation: rst asserted in DATA -> m_req and both data_ok low in the same cycle; after release, the first tie goes to data.
